// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states
// and the ISR word layout.
package irq_controller_pkg;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_ISR     = 2'd2;
    localparam logic [1:0] ADDR_EOI     = 2'd3;

    localparam int ISR_VALID_BIT = 31;
    localparam int ID_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [31:0] isr_word(input logic valid, input logic [ID_W-1:0] id);
        logic [31:0] w;
        w                = 32'd0;
        w[ISR_VALID_BIT] = valid;
        w[ID_W-1:0]      = id;
        return w;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral-bus register port plus the CPU request/acknowledge handshake.
interface irq_controller_if;
    logic        MemWrite;
    logic [1:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        irq_req;
    logic        irq_ack;

    modport master (
        output MemWrite, address, write_data, irq_ack,
        input  read_data, irq_req
    );

    modport slave (
        input  MemWrite, address, write_data, irq_ack,
        output read_data, irq_req
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the eligible vector.
module irq_prio_enc
    import irq_controller_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] eligible,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            winner = eligible[i] ? ID_W'(i) : winner;
            any    = any | eligible[i];
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-capturing, maskable interrupt controller handing one interrupt at a
// time to the CPU; software acknowledges completion with an EOI write.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    irq_controller_if.slave  bus
);

    logic [N_SRC-1:0] src_prev_r;
    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] mask_r;
    logic             isr_valid_r;
    logic [ID_W-1:0]  isr_id_r;
    irq_state_e       state_r;
    logic             irq_req_r;

    irq_state_e       state_s;
    logic [N_SRC-1:0] edge_s;
    logic [N_SRC-1:0] eligible_s;
    logic [N_SRC-1:0] clr_s;
    logic [N_SRC-1:0] pending_s;
    logic [ID_W-1:0]  winner_s;
    logic             any_s;
    logic             wr_pending_s;
    logic             wr_mask_s;
    logic             wr_eoi_s;
    logic             grant_s;
    logic             spurious_s;
    logic [31:0]      read_data_s;
    logic             unused_wdata_s;

    assign unused_wdata_s = ^bus.write_data[31:N_SRC];

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .eligible (eligible_s),
        .winner   (winner_s),
        .any      (any_s)
    );

    // Bus decode, edge detection and next-pending computation.
    always_comb begin
        wr_pending_s = bus.MemWrite && (bus.address == ADDR_PENDING);
        wr_mask_s    = bus.MemWrite && (bus.address == ADDR_MASK);
        wr_eoi_s     = bus.MemWrite && (bus.address == ADDR_EOI);
        edge_s       = irq_src & ~src_prev_r;
        eligible_s   = pending_r & mask_r;
        grant_s      = (state_r == ST_REQ) && bus.irq_ack && any_s;
        spurious_s   = (state_r == ST_REQ) && bus.irq_ack && !any_s;
        clr_s        = (wr_pending_s ? bus.write_data[N_SRC-1:0] : {N_SRC{1'b0}})
                     | (grant_s ? (N_SRC'(1) << winner_s) : {N_SRC{1'b0}});
        // A fresh edge wins over a same-cycle W1C or grant clear.
        pending_s    = (pending_r & ~clr_s) | edge_s;
    end

    // Grant FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) state_s = ST_REQ;
                else       state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.irq_ack)  state_s = any_s ? ST_SERVICE : ST_IDLE;
                else if (!any_s)  state_s = ST_IDLE;
                else              state_s = ST_REQ;
            end
            ST_SERVICE: begin
                if (wr_eoi_s) state_s = ST_IDLE;
                else          state_s = ST_SERVICE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered request output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            irq_req_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            irq_req_r <= (state_s == ST_REQ);
        end
    end

    // Edge history, pending and mask registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_prev_r <= '0;
            pending_r  <= '0;
            mask_r     <= '0;
        end else begin
            src_prev_r <= irq_src;
            pending_r  <= pending_s;
            if (wr_mask_s) mask_r <= bus.write_data[N_SRC-1:0];
            else           mask_r <= mask_r;
        end
    end

    // In-service register: set on grant, cleared by spurious ack or EOI.
    always_ff @(posedge clk) begin
        if (reset) begin
            isr_valid_r <= 1'b0;
            isr_id_r    <= '0;
        end else if (grant_s) begin
            isr_valid_r <= 1'b1;
            isr_id_r    <= winner_s;
        end else if (spurious_s || ((state_r == ST_SERVICE) && wr_eoi_s)) begin
            isr_valid_r <= 1'b0;
            isr_id_r    <= '0;
        end else begin
            isr_valid_r <= isr_valid_r;
            isr_id_r    <= isr_id_r;
        end
    end

    // Combinational register read mux.
    always_comb begin
        case (bus.address)
            ADDR_PENDING: read_data_s = 32'(pending_r);
            ADDR_MASK:    read_data_s = 32'(mask_r);
            ADDR_ISR:     read_data_s = isr_word(isr_valid_r, isr_id_r);
            ADDR_EOI:     read_data_s = 32'd0;
            default:      read_data_s = 32'd0;
        endcase
    end

    assign bus.read_data = read_data_s;
    assign bus.irq_req   = irq_req_r;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared against a behavioural model.
module tb_irq_controller;
    import irq_controller_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_src;

    irq_controller_if bus();

    irq_controller #(.N_SRC(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: 0 = idle, 1 = requesting, 2 = in service.
    bit m_pend [N];
    bit m_mask [N];
    bit m_prev [N];
    int m_state;
    bit m_isr_v;
    int m_isr_id;
    bit m_req;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [3:0]  src;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: for (int i = 0; i < N; i++) if (m_pend[i]) v = v + (32'd1 << i);
            2'd1: for (int i = 0; i < N; i++) if (m_mask[i]) v = v + (32'd1 << i);
            2'd2: v = (m_isr_v ? 32'h8000_0000 : 32'd0) + 32'(m_isr_id);
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_step();
        bit np [N];
        int win;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0; m_mask[i] = 1'b0; m_prev[i] = 1'b0;
            end
            m_state = 0; m_isr_v = 1'b0; m_isr_id = 0;
        end else begin
            win = -1;
            for (int i = 0; i < N; i++)
                if (m_pend[i] && m_mask[i] && win < 0) win = i;
            for (int i = 0; i < N; i++) np[i] = m_pend[i];
            if (bus.MemWrite && bus.address == 2'd0)
                for (int i = 0; i < N; i++) if (bus.write_data[i]) np[i] = 1'b0;
            if (m_state == 0) begin
                if (win >= 0) m_state = 1;
            end else if (m_state == 1) begin
                if (bus.irq_ack) begin
                    if (win >= 0) begin
                        m_isr_v = 1'b1; m_isr_id = win; np[win] = 1'b0; m_state = 2;
                    end else begin
                        m_isr_v = 1'b0; m_isr_id = 0; m_state = 0;
                    end
                end else if (win < 0) begin
                    m_state = 0;
                end
            end else begin
                if (bus.MemWrite && bus.address == 2'd3) begin
                    m_isr_v = 1'b0; m_isr_id = 0; m_state = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (irq_src[i] && !m_prev[i]) np[i] = 1'b1;
                m_prev[i] = irq_src[i];
            end
            if (bus.MemWrite && bus.address == 2'd1)
                for (int i = 0; i < N; i++) m_mask[i] = bus.write_data[i];
            for (int i = 0; i < N; i++) m_pend[i] = np[i];
        end
        m_req = (m_state == 1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] a, input logic [31:0] wd,
                         input logic [3:0] src, input logic ack);
        bus.MemWrite   = we;
        bus.address    = a;
        bus.write_data = wd;
        irq_src        = src;
        bus.irq_ack    = ack;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 4'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        check("reset_req", {31'd0, bus.irq_req}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.address = 2'(a);
            #1;
            check("reset_reg", bus.read_data, 32'd0);
        end

        vecs[0]  = '{1'b1, 2'd1, 32'hF, 4'h0, 1'b0, 1'b0, 32'h0000_000F};
        vecs[1]  = '{1'b0, 2'd0, 32'h0, 4'h4, 1'b0, 1'b0, 32'h0000_0004};
        vecs[2]  = '{1'b0, 2'd0, 32'h0, 4'h4, 1'b0, 1'b1, 32'h0000_0004};
        vecs[3]  = '{1'b0, 2'd2, 32'h0, 4'h4, 1'b1, 1'b0, 32'h8000_0002};
        vecs[4]  = '{1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b1, 2'd3, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 2'd2, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[7]  = '{1'b0, 2'd0, 32'h0, 4'hA, 1'b0, 1'b0, 32'h0000_000A};
        vecs[8]  = '{1'b0, 2'd0, 32'h0, 4'hA, 1'b0, 1'b1, 32'h0000_000A};
        vecs[9]  = '{1'b0, 2'd2, 32'h0, 4'hA, 1'b1, 1'b0, 32'h8000_0001};
        vecs[10] = '{1'b0, 2'd0, 32'h0, 4'hA, 1'b0, 1'b0, 32'h0000_0008};
        vecs[11] = '{1'b1, 2'd3, 32'h0, 4'hA, 1'b0, 1'b0, 32'h0000_0000};
        vecs[12] = '{1'b0, 2'd0, 32'h0, 4'hA, 1'b0, 1'b1, 32'h0000_0008};
        vecs[13] = '{1'b0, 2'd2, 32'h0, 4'hA, 1'b1, 1'b0, 32'h8000_0003};
        vecs[14] = '{1'b1, 2'd3, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[15] = '{1'b1, 2'd1, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[16] = '{1'b0, 2'd0, 32'h0, 4'h1, 1'b0, 1'b0, 32'h0000_0001};
        vecs[17] = '{1'b0, 2'd0, 32'h0, 4'h1, 1'b0, 1'b0, 32'h0000_0001};
        vecs[18] = '{1'b1, 2'd1, 32'h1, 4'h1, 1'b0, 1'b0, 32'h0000_0001};
        vecs[19] = '{1'b0, 2'd1, 32'h0, 4'h1, 1'b0, 1'b1, 32'h0000_0001};
        vecs[20] = '{1'b1, 2'd0, 32'h1, 4'h1, 1'b0, 1'b1, 32'h0000_0000};
        vecs[21] = '{1'b0, 2'd0, 32'h0, 4'h1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[22] = '{1'b0, 2'd2, 32'h0, 4'h1, 1'b1, 1'b0, 32'h0000_0000};

        foreach (vecs[k]) begin
            drive(vecs[k].we, vecs[k].addr, vecs[k].wd, vecs[k].src, vecs[k].ack);
            tick();
            check($sformatf("vec%0d_req", k), {31'd0, bus.irq_req}, {31'd0, vecs[k].exp_req});
            check($sformatf("vec%0d_rd", k), bus.read_data, vecs[k].exp_rd);
        end

        // Held-high source: serviced once, then no further request.
        drive(1'b0, 2'd0, 32'd0, 4'h0, 1'b0); tick();
        drive(1'b0, 2'd0, 32'd0, 4'h1, 1'b0); tick();
        drive(1'b0, 2'd0, 32'd0, 4'h1, 1'b0); tick();
        check("held_req", {31'd0, bus.irq_req}, 32'd1);
        drive(1'b0, 2'd2, 32'd0, 4'h1, 1'b1); tick();
        check("held_isr", bus.read_data, 32'h8000_0000);
        drive(1'b1, 2'd3, 32'd0, 4'h1, 1'b0); tick();
        drive(1'b0, 2'd0, 32'd0, 4'h1, 1'b0);
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.irq_req !== 1'b0 || bus.read_data !== 32'd0) begin
                check("held_quiet", {bus.read_data[30:0], bus.irq_req}, 32'd0);
            end else begin
                n_tests++;
            end
        end

        // W1C in the same cycle as a new edge: edge wins.
        drive(1'b0, 2'd0, 32'd0, 4'h0, 1'b0); tick();
        drive(1'b1, 2'd0, 32'd1, 4'h1, 1'b0); tick();
        bus.MemWrite = 1'b0;
        #1;
        check("w1c_edge_pend", bus.read_data, 32'h1);
        tick();
        check("w1c_edge_req", {31'd0, bus.irq_req}, 32'd1);
        drive(1'b0, 2'd2, 32'd0, 4'h0, 1'b1); tick();
        check("svc_isr", bus.read_data, 32'h8000_0000);

        // Reset while in service.
        bus.irq_ack = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_svc_req", {31'd0, bus.irq_req}, 32'd0);
        check("rst_svc_isr", bus.read_data, 32'd0);
        bus.address = 2'd0; #1;
        check("rst_svc_pend", bus.read_data, 32'd0);
        bus.address = 2'd1; #1;
        check("rst_svc_mask", bus.read_data, 32'd0);

        // Randomized traffic against the model.
        reset = 1'b1; tick(); reset = 1'b0;
        drive(1'b1, 2'd1, 32'hF, 4'h0, 1'b0); tick();
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 299) == 0);
            bus.MemWrite   = ($urandom_range(0, 5) == 0);
            bus.address    = 2'($urandom_range(0, 3));
            bus.write_data = $urandom;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) irq_src[i] = ~irq_src[i];
            bus.irq_ack    = ($urandom_range(0, 2) == 0);
            tick();
            check("rand_req", {31'd0, bus.irq_req}, {31'd0, m_req});
            check("rand_rd", bus.read_data, m_read(bus.address));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller between the external peripherals (Timer, UART, switch/button devices) and the pipeline CPU's exception logic. Captures rising edges on per-source request lines into a pending register, applies a software mask, and hands exactly one interrupt at a time to the CPU through a request/acknowledge handshake. Software reads the granted source ID and writes an end-of-interrupt (EOI) to allow the next one. Sits on the peripheral bus beside Timer with the same 2-bit-address, 32-bit-data register port.

## Interface
- N_SRC, 4, number of interrupt sources (1..16); source 0 highest priority.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- MemWrite  in  1  register write strobe.
- address  in  2  register select: 0 PENDING, 1 MASK, 2 ISR, 3 EOI.
- write_data  in  32  write data.
- read_data  out  32  combinational read of the selected register.
- irq_src  in  N_SRC  level request lines from peripherals (e.g. Timer IRQ).
- irq_req  out  1  interrupt request to CPU.
- irq_ack  in  1  one-cycle pulse from CPU when it enters the exception handler.

## Operation
- Registers, all zero-extended to 32 bits on read:
  - PENDING[N_SRC-1:0]: bit set on rising edge of irq_src[i] (1-cycle-registered previous value). Write: 1 clears bit (W1C), 0 no effect.
  - MASK[N_SRC-1:0]: read/write; 1 = source enabled.
  - ISR: bit 31 = valid, bits 3:0 = in-service source ID. Read-only; writes ignored.
  - EOI: write of any value ends service; reads return 0.
- Eligible = PENDING & MASK. Winner = lowest eligible index.
- FSM:
  - IDLE: irq_req=0. If eligible != 0, go to REQ next cycle.
  - REQ: irq_req=1. On irq_ack: if eligible != 0, latch winner into ISR (valid=1), clear that PENDING bit, go to SERVICE; if eligible == 0 (spurious), set ISR valid=0 and return to IDLE. With no ack and eligible dropping to 0 (masked or cleared), return to IDLE.
  - SERVICE: irq_req=0; no further grants (no nesting). EOI write -> clear ISR valid, go to IDLE. EOI written in IDLE/REQ is ignored.
- Simultaneous events: edge-set and W1C on the same bit in the same cycle -> bit ends set. Ack-clear and new edge on the same bit in the same cycle -> bit ends set. irq_ack outside REQ ignored.
- Level sources held high (Timer IRQ until software clears TCON) generate one pending event only; a new event requires low-then-high.

## Timing
- Reset: PENDING=0, MASK=0, ISR=0, edge-history=0, state IDLE, irq_req=0.
- irq_src rising at cycle t -> PENDING set visible at t+1 -> REQ and irq_req=1 at t+2 (if masked in).
- irq_ack sampled at edge t -> ISR valid and irq_req=0 from t+1.
- EOI at t -> IDLE at t+1; a remaining eligible source re-asserts irq_req at t+2.
- Register writes take effect next cycle; read_data is combinational from current state.
- Reset mid-REQ or SERVICE: returns to IDLE, all pending lost, next cycle.

## Structure
- Shared package/header: register address constants (ADDR_PENDING=0, ADDR_MASK=1, ADDR_ISR=2, ADDR_EOI=3), FSM state encodings, ISR valid bit position (31).
- One sub-module natural: irq_prio_enc, a combinational N_SRC-input lowest-index priority encoder producing winner ID and any-eligible flag.

## Test plan
- Reset, MASK=0xF, pulse irq_src[2] -> PENDING=0x4 next cycle, irq_req=1 two cycles after edge; ack -> ISR=0x80000002, PENDING=0, irq_req=0.
- irq_src=0b1010 same cycle, MASK=0xF -> ack grants ID 1, PENDING=0x8; EOI -> irq_req re-asserts, second ack grants ID 3.
- MASK=0x0, edge on src 0 -> PENDING=0x1, irq_req stays 0; write MASK=0x1 -> irq_req=1 two cycles later.
- In REQ, W1C PENDING=0x1 before ack -> back to IDLE, irq_req=0; late ack -> ignored, ISR stays 0.
- Src 0 held high 100 cycles after service and EOI -> no second request; W1C on same cycle as new edge -> bit remains 1.
- Reset asserted while in SERVICE with ISR=0x80000000 -> ISR=0, PENDING=0, irq_req=0 next cycle.
